jtag_tap_driver: RTL and testbench

- Host-side JTAG initiator for the SoC's TAP pins (tms/tck/tdi/tdo).
- Turns simple command-channel requests (TAP reset, IR scan, DR scan) into a bit-accurate TCK/TMS/TDI waveform.
- Captures TDO and returns it on a response channel.
- Sits in the testbench beside the CPU top-level and lets the bench drive the debug interface instead of leaving the pins floating.

---
 rtl/jtag_tap_driver_pkg.sv | 40 ++++
 rtl/jtag_tap_driver_tck_gen.sv | 38 +++
 rtl/jtag_tap_driver.sv | 175 +++++++++++++++++
 tb/tb_jtag_tap_driver.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_driver_pkg.sv
// Shared types and TMS sequence constants
// for the host-side JTAG TAP driver.
package jtag_tap_driver_pkg;

  typedef enum logic [1:0] {
    CMD_TAP_RESET = 2'd0,
    CMD_IR_SCAN   = 2'd1,
    CMD_DR_SCAN   = 2'd2,
    CMD_RSVD      = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_SEQ,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_RESP
  } state_e;

  // Bit i is the TMS value for tick i of the sequence
  localparam int RST_LEN    = 6;
  localparam int IR_PRE_LEN = 4;
  localparam int DR_PRE_LEN = 3;
  localparam int POST_LEN   = 2;

  localparam logic [7:0] RST_TMS    = 8'b0001_1111;
  localparam logic [7:0] IR_PRE_TMS = 8'b0000_0011;
  localparam logic [7:0] DR_PRE_TMS = 8'b0000_0001;
  localparam logic [7:0] POST_TMS   = 8'b0000_0001;

  function automatic logic [7:0] pre_tms(cmd_type_e t);
    return (t == CMD_IR_SCAN) ? IR_PRE_TMS : DR_PRE_TMS;
  endfunction

  function automatic int pre_len(cmd_type_e t);
    return (t == CMD_IR_SCAN) ? IR_PRE_LEN : DR_PRE_LEN;
  endfunction

endpackage

// File: rtl/jtag_tap_driver_tck_gen.sv
// TCK divider: TCK_DIV clocks low, TCK_DIV high,
// with single-cycle strobes on the clocks where TCK toggles.
module jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == CW'(TCK_DIV - 1));
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_tap_driver.sv
// Command-channel JTAG initiator: TAP reset,
// IR and DR scans with TDO capture.
module jtag_tap_driver
  import jtag_tap_driver_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [1:0]                   cmd_type_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len_i,
  input  logic [MAX_LEN-1:0]           cmd_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [MAX_LEN-1:0]           rsp_data_o,
  output logic                         rsp_err_o,
  output logic                         tck_o,
  output logic                         tms_o,
  output logic                         tdi_o,
  input  logic                         tdo_i,
  output logic                         busy_o
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e             state;
  cmd_type_e          ctype;
  logic [LW-1:0]      clen;
  logic [LW-1:0]      idx;
  logic [MAX_LEN-1:0] sdata;
  logic [7:0]         tseq;
  logic               synced;
  logic               fall_stb;
  logic               rise_stb;
  logic               bad;
  logic [7:0]         pre_now;
  logic [7:0]         pre_lat;

  assign busy_o = (state == S_RESET_SEQ) || (state == S_PRE) ||
                  (state == S_SHIFT) || (state == S_POST);

  assign bad = (cmd_type_i == CMD_RSVD) || (cmd_len_i == '0) ||
               (cmd_len_i > LW'(MAX_LEN));

  assign pre_now = pre_tms(cmd_type_e'(cmd_type_i));
  assign pre_lat = pre_tms(ctype);

  jtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .en       (busy_o),
    .tck      (tck_o),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      ctype       <= CMD_TAP_RESET;
      clen        <= '0;
      idx         <= '0;
      sdata       <= '0;
      tseq        <= '0;
      synced      <= 1'b0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            ctype       <= cmd_type_e'(cmd_type_i);
            clen        <= cmd_len_i;
            sdata       <= cmd_data_i;
            idx         <= '0;
            tdi_o       <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            if (bad) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else if (cmd_type_i == CMD_TAP_RESET || !synced) begin
              state <= S_RESET_SEQ;
              tms_o <= RST_TMS[0];
              tseq  <= RST_TMS >> 1;
            end else begin
              state <= S_PRE;
              tms_o <= pre_now[0];
              tseq  <= pre_now >> 1;
            end
          end
        end
        S_RESET_SEQ: if (fall_stb) begin
          tms_o <= tseq[0];
          tseq  <= tseq >> 1;
          idx   <= idx + LW'(1);
          if (idx == LW'(RST_LEN - 1)) begin
            synced <= 1'b1;
            idx    <= '0;
            if (ctype == CMD_TAP_RESET) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              tms_o       <= 1'b0;
            end else begin
              state <= S_PRE;
              tms_o <= pre_lat[0];
              tseq  <= pre_lat >> 1;
            end
          end
        end
        S_PRE: if (fall_stb) begin
          tms_o <= tseq[0];
          tseq  <= tseq >> 1;
          idx   <= idx + LW'(1);
          if (idx == LW'(pre_len(ctype) - 1)) begin
            state <= S_SHIFT;
            idx   <= '0;
            tdi_o <= sdata[0];
            sdata <= sdata >> 1;
            tms_o <= (clen == LW'(1));
          end
        end
        S_SHIFT: begin
          // Captured bits enter at the top and are aligned on exit
          if (rise_stb)
            rsp_data_o <= {tdo_i, rsp_data_o[MAX_LEN-1:1]};
          if (fall_stb) begin
            if (idx == clen - LW'(1)) begin
              state      <= S_POST;
              idx        <= '0;
              tdi_o      <= 1'b0;
              tms_o      <= POST_TMS[0];
              tseq       <= POST_TMS >> 1;
              rsp_data_o <= rsp_data_o >> (MAX_LEN - int'(clen));
            end else begin
              idx   <= idx + LW'(1);
              tdi_o <= sdata[0];
              sdata <= sdata >> 1;
              tms_o <= (idx == clen - LW'(2));
            end
          end
        end
        S_POST: if (fall_stb) begin
          tms_o <= tseq[0];
          tseq  <= tseq >> 1;
          idx   <= idx + LW'(1);
          if (idx == LW'(POST_LEN - 1)) begin
            state       <= S_RESP;
            idx         <= '0;
            rsp_valid_o <= 1'b1;
          end
        end
        S_RESP: if (rsp_ready_i) begin
          state       <= S_IDLE;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: pin-level TAP model plus
// a transaction-level reference for expected responses.
module tb_jtag_tap_driver;

  localparam int TCK_DIV = 2;
  localparam int MAX_LEN = 64;
  localparam int LW = 7;
  localparam logic [3:0] IR_BYPASS = 4'h8;
  localparam logic [3:0] IR_IDCODE = 4'h2;
  localparam logic [3:0] IR_CAP = 4'h1;
  localparam logic [31:0] IDCODE = 32'h4BA0_0477;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3;
  localparam int SHDR = 4, EX1DR = 5, PDR = 6, EX2DR = 7;
  localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11;
  localparam int EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_type = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic rsp_err;
  logic tck, tms, tdi;
  logic tdo = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  jtag_tap_driver #(
    .TCK_DIV (TCK_DIV),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_type_i  (cmd_type),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .tck_o       (tck),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo),
    .busy_o      (busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural TAP on the pins
  int tap_st = RTI;
  logic [3:0] ir = IR_IDCODE;
  logic [3:0] ir_sr = '0;
  logic [31:0] dr_sr = '0;
  int rise_cnt = 0;
  bit tms_q[$];

  function automatic int tap_next(int s, logic m);
    case (s)
      TLR:   return m ? TLR : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR : PDR;
      PDR:   return m ? EX2DR : PDR;
      EX2DR: return m ? UPDR : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR : PIR;
      PIR:   return m ? EX2IR : PIR;
      EX2IR: return m ? UPIR : SHIR;
      UPIR:  return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_q.push_back(tms);
    rise_cnt++;
    case (tap_st)
      CAPDR: dr_sr = (ir == IR_BYPASS) ? 32'd0 : IDCODE;
      SHDR:  dr_sr = (ir == IR_BYPASS) ? {31'd0, tdi} : {tdi, dr_sr[31:1]};
      CAPIR: ir_sr = IR_CAP;
      SHIR:  ir_sr = {tdi, ir_sr[3:1]};
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
    if (tap_st == UPIR) ir = ir_sr;
    if (tap_st == TLR) ir = IR_IDCODE;
  end

  always @(negedge tck)
    tdo = (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

  // Transaction-level reference
  bit ref_synced = 0;
  logic [3:0] ref_ir = IR_IDCODE;
  bit exp_tms[$];

  task automatic ref_cmd(input logic [1:0] t, input int n,
                         input logic [63:0] d,
                         output logic [63:0] data, output logic err);
    logic [127:0] comb, mask;
    int l;
    exp_tms.delete();
    data = '0;
    err = 1'b0;
    if (t == 2'd3 || n == 0 || n > MAX_LEN) begin
      err = 1'b1;
      return;
    end
    if (t == 2'd0 || !ref_synced) begin
      for (int i = 0; i < 6; i++) exp_tms.push_back(i < 5);
      ref_synced = 1;
      ref_ir = IR_IDCODE;
    end
    if (t == 2'd0) return;
    mask = (128'd1 << n) - 128'd1;
    if (t == 2'd1) begin
      exp_tms.push_back(1); exp_tms.push_back(1);
      exp_tms.push_back(0); exp_tms.push_back(0);
      comb = ({64'd0, d} << 4) | {124'd0, IR_CAP};
      ref_ir = 4'(comb >> n);
    end else begin
      exp_tms.push_back(1); exp_tms.push_back(0); exp_tms.push_back(0);
      l = (ref_ir == IR_BYPASS) ? 1 : 32;
      comb = ({64'd0, d} << l) |
             ((ref_ir == IR_BYPASS) ? 128'd0 : {96'd0, IDCODE});
    end
    data = 64'(comb & mask);
    for (int i = 0; i < n; i++) exp_tms.push_back(i == n - 1);
    exp_tms.push_back(1);
    exp_tms.push_back(0);
  endtask

  function automatic bit tms_mismatch();
    if (tms_q.size() != exp_tms.size()) return 1;
    foreach (exp_tms[i]) if (tms_q[i] != exp_tms[i]) return 1;
    return 0;
  endfunction

  task automatic run_cmd(input logic [1:0] t, input int n,
                         input logic [63:0] d,
                         output logic [63:0] data, output logic err,
                         output int busy_cyc, output int rises,
                         output bit ok);
    int r0;
    ok = 0;
    busy_cyc = 0;
    data = '0;
    err = 1'b0;
    for (int k = 0; k < 100 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    tms_q.delete();
    r0 = rise_cnt;
    if (cmd_ready) begin
      cmd_valid = 1'b1;
      cmd_type = t;
      cmd_len = LW'(n);
      cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < 2000; k++) begin
        if (busy) busy_cyc++;
        if (rsp_valid) begin
          ok = 1;
          break;
        end
        @(posedge clk); #1;
      end
      if (ok) begin
        data = rsp_data;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end
    end
    rises = rise_cnt - r0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy} !== 7'b0100000 ||
        rsp_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_vals: got tck%b tms%b tdi%b rdy%b vld%b err%b busy%b data %h",
               tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy, rsp_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_tap_reset();
    logic [63:0] g, e;
    logic ge, ee;
    int bc, rc;
    bit ok;
    run_cmd(2'd0, 8, 64'hDEAD, g, ge, bc, rc, ok);
    ref_cmd(2'd0, 8, 64'hDEAD, e, ee);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tap_reset_timeout"); end
    n_checks++;
    if (rc !== 6 || bc !== 24) begin
      n_fail++;
      $display("FAIL tap_reset_ticks: got %0d ticks %0d clocks want 6 24", rc, bc);
    end
    n_checks++;
    if (tms_mismatch()) begin
      n_fail++;
      $display("FAIL tap_reset_tms: got %p want %p", tms_q, exp_tms);
    end
    n_checks++;
    if (g !== e || ge !== ee || tap_st !== RTI) begin
      n_fail++;
      $display("FAIL tap_reset_rsp: got %h err %b st %0d want %h err %b st %0d",
               g, ge, tap_st, e, ee, RTI);
    end
  endtask

  task automatic test_ir_scan();
    logic [63:0] g, e;
    logic ge, ee;
    int bc, rc;
    bit ok;
    run_cmd(2'd1, 4, 64'h8, g, ge, bc, rc, ok);
    ref_cmd(2'd1, 4, 64'h8, e, ee);
    n_checks++;
    if (!ok || g !== 64'h1 || g !== e || ge !== 1'b0) begin
      n_fail++;
      $display("FAIL ir_scan_data: got %h err %b ok %b want 1", g, ge, ok);
    end
    n_checks++;
    if (tms_mismatch() || rc !== 10 || bc !== 40) begin
      n_fail++;
      $display("FAIL ir_scan_tms: got %p (%0d ticks) want %p", tms_q, rc, exp_tms);
    end
    n_checks++;
    if (ir !== IR_BYPASS) begin
      n_fail++;
      $display("FAIL ir_scan_ir: got %h want %h", ir, IR_BYPASS);
    end
  endtask

  task automatic test_dr_bypass();
    logic [63:0] g, e;
    logic ge, ee;
    int bc, rc;
    bit ok;
    run_cmd(2'd2, 8, 64'hA5, g, ge, bc, rc, ok);
    ref_cmd(2'd2, 8, 64'hA5, e, ee);
    n_checks++;
    if (!ok || g !== 64'h4A || g !== e) begin
      n_fail++;
      $display("FAIL dr_bypass_data: got %h want 4a", g);
    end
    n_checks++;
    if (rc !== 13 || tms_mismatch()) begin
      n_fail++;
      $display("FAIL dr_bypass_ticks: got %0d want 13", rc);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ts[3] = '{2'd2, 2'd1, 2'd3};
    int ls[3] = '{0, MAX_LEN + 1, 8};
    logic [63:0] g, e;
    logic ge, ee;
    int bc, rc;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      run_cmd(ts[i], ls[i], 64'hFFFF_0000_1234_5678, g, ge, bc, rc, ok);
      ref_cmd(ts[i], ls[i], 64'hFFFF_0000_1234_5678, e, ee);
      n_checks++;
      if (!ok || ge !== 1'b1 || g !== 64'd0 || rc !== 0 || bc !== 0) begin
        n_fail++;
        $display("FAIL illegal_%0d: got err %b data %h ticks %0d busy %0d ok %b want err 1 no ticks",
                 i, ge, g, rc, bc, ok);
      end
    end
    run_cmd(2'd2, 64, '1, g, ge, bc, rc, ok);
    ref_cmd(2'd2, 64, '1, e, ee);
    n_checks++;
    if (!ok || g !== 64'hFFFF_FFFF_FFFF_FFFE || g !== e || ge !== 1'b0 || rc !== 69) begin
      n_fail++;
      $display("FAIL full_len: got %h err %b ticks %0d want fffffffffffffffe 0 69", g, ge, rc);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d, e, v;
    logic ee, ve;
    bit ok, stable;
    int r0;
    d = 64'(10'h2B7);
    ref_cmd(2'd2, 10, d, e, ee);
    for (int k = 0; k < 100 && !cmd_ready; k++) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_len = LW'(10); cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    v = rsp_data;
    ve = rsp_err;
    r0 = rise_cnt;
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_len = LW'(5);
    stable = 1;
    repeat (50) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== v || rsp_err !== ve || cmd_ready || busy)
        stable = 0;
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (!ok || !stable || rise_cnt !== r0) begin
      n_fail++;
      $display("FAIL backpressure_hold: ok %b stable %b ticks %0d", ok, stable, rise_cnt - r0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (v !== e || ve !== ee) begin
      n_fail++;
      $display("FAIL backpressure_data: got %h want %h", v, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rise_cnt !== r0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got rdy %b vld %b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] g, e;
    logic ge, ee;
    int bc, rc, r0;
    bit ok, quiet;
    for (int k = 0; k < 100 && !cmd_ready; k++) begin @(posedge clk); #1; end
    r0 = rise_cnt;
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_len = LW'(40);
    cmd_data = {$urandom, $urandom};
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 500 && rise_cnt - r0 < 10; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rise_cnt - r0 < 10 || tck !== 1'b0 || tms !== 1'b1 || busy !== 1'b0 ||
        rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_pins: got tck %b tms %b busy %b vld %b want 0 1 0 0",
               tck, tms, busy, rsp_valid);
    end
    ref_synced = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = rise_cnt;
    quiet = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) quiet = 0;
    end
    n_checks++;
    if (!quiet || rise_cnt !== r0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got stray response or ticks %0d", rise_cnt - r0);
    end
    run_cmd(2'd2, 12, 64'hABC, g, ge, bc, rc, ok);
    ref_cmd(2'd2, 12, 64'hABC, e, ee);
    n_checks++;
    if (!ok || rc !== 23 || tms_mismatch() || g !== e) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got %h ticks %0d want %h 23", g, rc, e);
    end
  endtask

  task automatic test_auto_prefix();
    logic [63:0] g1, g2, e, d;
    logic ge, ee;
    int bc, rc;
    bit ok;
    d = 64'($urandom);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_synced = 0;
    run_cmd(2'd2, 16, d, g1, ge, bc, rc, ok);
    ref_cmd(2'd2, 16, d, e, ee);
    n_checks++;
    if (!ok || rc !== 27 || tms_mismatch() || g1 !== e) begin
      n_fail++;
      $display("FAIL auto_prefix: got %h ticks %0d want %h 27", g1, rc, e);
    end
    run_cmd(2'd0, 1, '0, g2, ge, bc, rc, ok);
    ref_cmd(2'd0, 1, '0, e, ee);
    run_cmd(2'd2, 16, d, g2, ge, bc, rc, ok);
    ref_cmd(2'd2, 16, d, e, ee);
    n_checks++;
    if (!ok || rc !== 21 || g2 !== g1 || g2 !== e) begin
      n_fail++;
      $display("FAIL explicit_reset_scan: got %h ticks %0d want %h 21", g2, rc, g1);
    end
  endtask

  task automatic test_random();
    logic [63:0] g, e, d;
    logic ge, ee;
    logic [1:0] t;
    int bc, rc, n, r;
    bit ok;
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      t = (r == 0) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 66) : $urandom_range(1, 20);
      d = {$urandom, $urandom};
      run_cmd(t, n, d, g, ge, bc, rc, ok);
      ref_cmd(t, n, d, e, ee);
      n_checks++;
      if (!ok || g !== e || ge !== ee) begin
        n_fail++;
        $display("FAIL rand_%0d_rsp: type %0d len %0d got %h err %b want %h err %b",
                 it, t, n, g, ge, e, ee);
      end
      n_checks++;
      if (rc !== exp_tms.size() || bc !== 4 * rc || tms_mismatch()) begin
        n_fail++;
        $display("FAIL rand_%0d_wave: ticks %0d clocks %0d want %0d ticks",
                 it, rc, bc, exp_tms.size());
      end
      n_checks++;
      if (!ee && tap_st !== RTI) begin
        n_fail++;
        $display("FAIL rand_%0d_tap_state: got %0d want %0d", it, tap_st, RTI);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_ir_scan();
    test_dr_bypass();
    test_illegal();
    test_backpressure();
    test_reset_mid_shift();
    test_auto_prefix();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
